// File: rtl/vpu_exec_writeback_pkg.sv
// Shared types and defaults for the VPU result writeback block.
package vpu_exec_writeback_pkg;

    localparam int VPU_WB_FIFO_DEPTH = 4;
    localparam int VPU_WB_LEN_WIDTH  = 8;
    localparam int VPU_WB_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } vpu_wb_state_t;

    typedef struct packed {
        logic [VPU_WB_ADDR_WIDTH-1:0] base;
        logic [VPU_WB_ADDR_WIDTH-1:0] stride;
        logic [VPU_WB_LEN_WIDTH-1:0]  len;
    } vpu_wb_cfg_t;

endpackage

// File: rtl/vpu_exec_writeback_if.sv
// Command, result and write-port bundle; slave is the writeback block, master the issuer/buffer side.
interface vpu_wb_if #(
    parameter int DWIDTH     = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
);
    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    logic [ADDR_WIDTH-1:0] cfg_base_i;
    logic [ADDR_WIDTH-1:0] cfg_stride_i;
    logic [LEN_WIDTH-1:0]  cfg_len_i;
    logic                  res_valid_i;
    logic [DWIDTH-1:0]     res_data_i;
    logic                  exec_ready_o;
    logic                  wr_valid_o;
    logic                  wr_ready_i;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DWIDTH-1:0]     wr_data_o;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  cfg_valid_i, cfg_base_i, cfg_stride_i, cfg_len_i,
        input  res_valid_i, res_data_i, wr_ready_i,
        output cfg_ready_o, exec_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
        output done_o, err_o
    );

    modport master (
        output cfg_valid_i, cfg_base_i, cfg_stride_i, cfg_len_i,
        output res_valid_i, res_data_i, wr_ready_i,
        input  cfg_ready_o, exec_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
        input  done_o, err_o
    );
endinterface

// File: rtl/vpu_exec_writeback_fifo.sv
// Small synchronous FIFO with a registered head word; push and pop may coincide at any occupancy.
module vpu_wb_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The word behind the head is never the one being written, since writes land at rd_ptr+count.
            if (do_pop) begin
                if (count_reg > CW'(1))
                    head_reg <= mem[rd_ptr_reg + 1'b1];
                else if (do_push)
                    head_reg <= din;
            end else if (do_push && count_reg == '0) begin
                head_reg <= din;
            end
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
endmodule

// File: rtl/vpu_exec_writeback.sv
// Buffers exec-unit results and writes them to base + k*stride, one command at a time.
module vpu_exec_writeback
    import vpu_exec_writeback_pkg::*;
#(
    parameter int DWIDTH     = 256,
    parameter int ADDR_WIDTH = VPU_WB_ADDR_WIDTH,
    parameter int LEN_WIDTH  = VPU_WB_LEN_WIDTH,
    parameter int FIFO_DEPTH = VPU_WB_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    vpu_wb_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACTIVE = ACTIVE;
    localparam logic [1:0] ST_DONE   = DONE;

    logic [1:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] next_addr_reg, stride_reg;
    logic [LEN_WIDTH-1:0]  len_reg, acc_cnt_reg, wr_cnt_reg;
    logic                  err_reg;
    logic                  push, pop, cfg_fire;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DWIDTH-1:0]     fifo_head;

    assign cfg_fire = (state_reg == ST_IDLE) && bus.cfg_valid_i;
    assign pop      = !fifo_empty && bus.wr_ready_i;
    // A full FIFO can still take a result when the write port drains one in the same cycle.
    assign push     = bus.res_valid_i && (state_reg == ST_ACTIVE) &&
                      (acc_cnt_reg != len_reg) && (!fifo_full || pop);

    vpu_wb_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (bus.res_data_i),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.cfg_valid_i)
                           state_next = (bus.cfg_len_i == '0) ? ST_DONE : ST_ACTIVE;
            ST_ACTIVE: if (pop && wr_cnt_reg == len_reg - LEN_WIDTH'(1))
                           state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            next_addr_reg <= '0;
            stride_reg    <= '0;
            len_reg       <= '0;
            acc_cnt_reg   <= '0;
            wr_cnt_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cfg_fire) begin
                next_addr_reg <= bus.cfg_base_i;
                stride_reg    <= bus.cfg_stride_i;
                len_reg       <= bus.cfg_len_i;
                acc_cnt_reg   <= '0;
                wr_cnt_reg    <= '0;
            end else begin
                if (push) acc_cnt_reg <= acc_cnt_reg + 1'b1;
                if (pop) begin
                    wr_cnt_reg    <= wr_cnt_reg + 1'b1;
                    next_addr_reg <= next_addr_reg + stride_reg;
                end
            end
            // Any result that could not be accepted is lost; flag it until reset.
            if (bus.res_valid_i && !push) err_reg <= 1'b1;
        end
    end

    assign bus.cfg_ready_o  = (state_reg == ST_IDLE);
    assign bus.exec_ready_o = (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign bus.wr_valid_o   = !fifo_empty;
    assign bus.wr_addr_o    = next_addr_reg;
    assign bus.wr_data_o    = fifo_head;
    assign bus.done_o       = (state_reg == ST_DONE);
    assign bus.err_o        = err_reg;
endmodule

// File: tb/tb_vpu_exec_writeback.sv
// Directed bench: stimulus pushes expected writes into a queue, a negedge monitor pops and compares.
module tb_vpu_exec_writeback;
    import vpu_exec_writeback_pkg::*;

    localparam int DW = 256;
    localparam int AW = 16;
    localparam int LW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic    clk   = 1'b0;
    logic    rst_n = 1'b0;
    int      n_vec = 0;
    int      n_miss = 0;
    int      done_cnt = 0;
    wr_exp_t exp_q[$];

    always #5 clk = ~clk;

    vpu_wb_if #(.DWIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus();

    vpu_exec_writeback #(
        .DWIDTH     (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dv(input int k);
        return {8{32'h5A5A_0000 | 32'(k)}};
    endfunction

    // Monitor: scoreboard for writes, hold-stability under stall, done pulse counting.
    logic          prev_stall = 1'b0;
    logic          prev_done  = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        wr_exp_t e;
        if (rst_n) begin
            if (prev_stall && bus.wr_valid_o) begin
                check("hold_addr", bus.wr_addr_o, prev_addr);
                check("hold_data", bus.wr_data_o, prev_data);
            end
            if (bus.wr_valid_o && bus.wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: got addr %0h, required no write", bus.wr_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr_o, e.addr);
                    check("wr_data", bus.wr_data_o, e.data);
                    $display("write addr=%h data=%h", bus.wr_addr_o, bus.wr_data_o);
                end
            end
            if (bus.done_o) begin
                check("done_width", prev_done, 1'b0);
                done_cnt++;
            end
        end
        prev_stall = rst_n && bus.wr_valid_o && !bus.wr_ready_i;
        prev_done  = rst_n && bus.done_o;
        prev_addr  = bus.wr_addr_o;
        prev_data  = bus.wr_data_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic send_cfg(input vpu_wb_cfg_t c);
        int t = 0;
        while (!bus.cfg_ready_o && t < 50) begin
            tick(1);
            t++;
        end
        if (!bus.cfg_ready_o) check("cfg_ready_timeout", bus.cfg_ready_o, 1'b1);
        bus.cfg_valid_i  = 1'b1;
        bus.cfg_base_i   = c.base;
        bus.cfg_stride_i = c.stride;
        bus.cfg_len_i    = c.len;
        tick(1);
        bus.cfg_valid_i  = 1'b0;
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        bus.res_valid_i = 1'b1;
        bus.res_data_i  = d;
        tick(1);
        bus.res_valid_i = 1'b0;
    endtask

    task automatic wait_exec_ready();
        int t = 0;
        while (!bus.exec_ready_o && t < 50) begin
            tick(1);
            t++;
        end
        if (!bus.exec_ready_o) check("exec_ready_timeout", bus.exec_ready_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, required earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid_i  = 1'b0;
        bus.cfg_base_i   = '0;
        bus.cfg_stride_i = '0;
        bus.cfg_len_i    = '0;
        bus.res_valid_i  = 1'b0;
        bus.res_data_i   = '0;
        bus.wr_ready_i   = 1'b0;
        tick(2);
        check("rst_cfg_ready", bus.cfg_ready_o, 1'b1);
        check("rst_exec_ready", bus.exec_ready_o, 1'b1);
        check("rst_wr_valid", bus.wr_valid_o, 1'b0);
        check("rst_wr_addr", bus.wr_addr_o, '0);
        check("rst_wr_data", bus.wr_data_o, '0);
        check("rst_done", bus.done_o, 1'b0);
        check("rst_err", bus.err_o, 1'b0);
        rst_n = 1'b1;
        tick(1);

        // Basic command: three spaced results, free-flowing write port.
        bus.wr_ready_i = 1'b1;
        push_exp(16'h0100, dv(1));
        push_exp(16'h0104, dv(2));
        push_exp(16'h0108, dv(3));
        send_cfg('{base: 16'h0100, stride: 16'd4, len: 8'd3});
        for (int k = 1; k <= 3; k++) begin
            pulse(dv(k));
            check("t1_latency", bus.wr_valid_o, 1'b1);
            if (k < 3) tick(4);
        end
        tick(1);
        check("t1_done_pulse", bus.done_o, 1'b1);
        tick(1);
        check("t1_done_low", bus.done_o, 1'b0);
        check("t1_err", bus.err_o, 1'b0);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_done_cnt", done_cnt, 1);

        // Back-pressure: stalled write port fills the FIFO.
        bus.wr_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) push_exp(16'h0200 + 16'(k), dv(11 + k));
        send_cfg('{base: 16'h0200, stride: 16'd1, len: 8'd4});
        for (int k = 1; k <= 3; k++) begin
            pulse(dv(10 + k));
            check("t2_exec_ready", bus.exec_ready_o, (k <= 2) ? 1'b1 : 1'b0);
            tick(2);
        end
        tick(11);
        check("t2_exec_ready_held", bus.exec_ready_o, 1'b0);
        check("t2_wr_valid", bus.wr_valid_o, 1'b1);
        check("t2_head_addr", bus.wr_addr_o, 16'h0200);
        check("t2_head_data", bus.wr_data_o, dv(11));
        bus.wr_ready_i = 1'b1;
        wait_exec_ready();
        pulse(dv(14));
        tick(10);
        check("t2_done_cnt", done_cnt, 2);
        check("t2_err", bus.err_o, 1'b0);
        check("t2_q_empty", exp_q.size(), 0);

        // Address wrap.
        push_exp(16'hFFFC, dv(21));
        push_exp(16'h0004, dv(22));
        send_cfg('{base: 16'hFFFC, stride: 16'd8, len: 8'd2});
        pulse(dv(21));
        tick(1);
        pulse(dv(22));
        tick(10);
        check("t3_done_cnt", done_cnt, 3);
        check("t3_q_empty", exp_q.size(), 0);

        // Zero-length command.
        send_cfg('{base: 16'h0400, stride: 16'd1, len: 8'd0});
        check("t4_cfg_ready_low", bus.cfg_ready_o, 1'b0);
        check("t4_done", bus.done_o, 1'b1);
        check("t4_wr_valid", bus.wr_valid_o, 1'b0);
        tick(1);
        check("t4_cfg_ready_back", bus.cfg_ready_o, 1'b1);
        check("t4_done_low", bus.done_o, 1'b0);
        tick(3);
        check("t4_done_cnt", done_cnt, 4);

        // Errors: result while idle, then an excess result on a len=2 command.
        pulse(dv(99));
        check("t5_err_idle", bus.err_o, 1'b1);
        tick(2);
        check("t5_err_sticky", bus.err_o, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("t5_err_reset", bus.err_o, 1'b0);
        rst_n = 1'b1;
        bus.wr_ready_i = 1'b0;
        push_exp(16'h0300, dv(31));
        push_exp(16'h0302, dv(32));
        send_cfg('{base: 16'h0300, stride: 16'd2, len: 8'd2});
        pulse(dv(31));
        pulse(dv(32));
        check("t5_err_before", bus.err_o, 1'b0);
        pulse(dv(33));
        check("t5_err_excess", bus.err_o, 1'b1);
        tick(2);
        bus.wr_ready_i = 1'b1;
        tick(10);
        check("t5_done_cnt", done_cnt, 5);
        check("t5_err_kept", bus.err_o, 1'b1);
        check("t5_q_empty", exp_q.size(), 0);

        // Reset in the middle of a command with two buffered results.
        bus.wr_ready_i = 1'b0;
        send_cfg('{base: 16'h0500, stride: 16'd1, len: 8'd4});
        pulse(dv(41));
        pulse(dv(42));
        tick(1);
        check("t6_wr_valid_pre", bus.wr_valid_o, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("t6_wr_valid", bus.wr_valid_o, 1'b0);
        check("t6_cfg_ready", bus.cfg_ready_o, 1'b1);
        check("t6_err", bus.err_o, 1'b0);
        check("t6_exec_ready", bus.exec_ready_o, 1'b1);
        check("t6_done", bus.done_o, 1'b0);
        rst_n = 1'b1;
        bus.wr_ready_i = 1'b1;
        tick(10);
        check("t6_done_cnt", done_cnt, 5);
        check("t6_wr_valid_after", bus.wr_valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
